// File: rtl/lstm_gate_preact.sv
// lstm_gate_preact
//
// One LSTM gate pre-activation, z = b + sum(w_i * x_i), in Q8.8. A serial
// stream of (weight, operand) beats is multiplied, accumulated in a wide
// Q(ACC_W-16).16 accumulator, then rounded half-up and narrowed back to Q8.8.
// The result goes to the sigmoid stage over a valid/ready handshake.
//
// Build option:
//   LSTM_PREACT_SAT_EN  defined   -> result clips to 0x7FFF/0x8000, o_sat_flag live
//                       undefined -> result wraps (two's complement), o_sat_flag = 0
//
// Ports:
//   i_clock       sole clock, rising edge
//   i_reset       synchronous active-high reset, clears all state
//   i_in_valid    beat valid
//   o_in_ready    block can accept a beat
//   i_in_last     final beat of the vector
//   i_weight      signed Q8.8 weight
//   i_operand     signed Q8.8 operand (x or h element)
//   i_bias        signed Q8.8 bias, sampled on the first beat of a vector only
//   o_out_valid   o_packet_out holds a result
//   i_out_ready   downstream accepts the result
//   o_packet_out  data field of the sigmoid input packet (Q8.8 pre-activation)
//   o_sat_flag    result was clipped (valid with o_out_valid)
//   o_len_err     vector hit MAX_LEN beats without i_in_last (valid with o_out_valid)

module lstm_gate_preact #(
    parameter int unsigned XLEN    = 16,  // LSTM_INPUT_BITS
    parameter int unsigned FRAC    = 8,
    parameter int unsigned ACC_W   = 40,
    parameter int unsigned MAX_LEN = 64
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic            i_in_last,
    input  logic [XLEN-1:0] i_weight,
    input  logic [XLEN-1:0] i_operand,
    input  logic [XLEN-1:0] i_bias,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_packet_out,
    output logic            o_sat_flag,
    output logic            o_len_err
);

    localparam int unsigned CNT_W  = $clog2(MAX_LEN) + 1;
    localparam int unsigned PROD_W = 2 * XLEN;
    // Width of the rounded, shifted accumulator (one guard bit for the rounding add).
    localparam int unsigned R_W    = ACC_W + 1 - FRAC;

    localparam logic signed [ACC_W:0] RndHalf = (ACC_W + 1)'(1) << (FRAC - 1);
    localparam logic [CNT_W-1:0]      CntLast = CNT_W'(MAX_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAccum,
        StFlush,
        StRound,
        StHold
    } state_e;

    state_e                    r_state;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [PROD_W-1:0]  r_prod;
    logic                      r_prod_vld;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_len_err;

    logic                      w_beat;
    logic                      w_cnt_at_max;
    logic                      w_end_vec;
    logic signed [PROD_W-1:0]  w_product;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_bias_ext;
    logic signed [ACC_W:0]     w_acc_rnd;
    logic signed [R_W-1:0]     w_r;
    logic [XLEN-1:0]           w_res;
    logic                      w_sat;

    // Gated by reset so the port reads 0 during the reset cycle itself.
    assign o_in_ready = !i_reset && ((r_state == StIdle) || (r_state == StAccum));
    assign w_beat     = i_in_valid && o_in_ready;

    // The counter holds the number of beats already accepted in this vector, so
    // the MAX_LEN-th beat is the one that arrives while it reads MAX_LEN-1.
    assign w_cnt_at_max = (r_cnt == CntLast);
    assign w_end_vec    = i_in_last || w_cnt_at_max;

    assign w_product  = $signed(i_weight) * $signed(i_operand);
    assign w_prod_ext = {{(ACC_W - PROD_W){r_prod[PROD_W-1]}}, r_prod};
    // Q8.8 bias aligned to the Q.16 accumulator.
    assign w_bias_ext = {{(ACC_W - XLEN - FRAC){i_bias[XLEN-1]}}, i_bias, {FRAC{1'b0}}};

    // Round half up, then arithmetic shift right by FRAC.
    assign w_acc_rnd = {r_acc[ACC_W-1], r_acc} + RndHalf;
    assign w_r       = w_acc_rnd[ACC_W:FRAC];

`ifdef LSTM_PREACT_SAT_EN
    localparam logic signed [R_W-1:0] ResMax = R_W'((64'(1) << (XLEN - 1)) - 64'(1));
    localparam logic signed [R_W-1:0] ResMin = ~ResMax;

    logic w_sat_hi;
    logic w_sat_lo;
    logic w_unused_rnd;

    assign w_sat_hi = (w_r > ResMax);
    assign w_sat_lo = (w_r < ResMin);
    assign w_sat    = w_sat_hi || w_sat_lo;

    always_comb begin
        w_res = w_r[XLEN-1:0];
        if (w_sat_hi) begin
            w_res = {1'b0, {(XLEN - 1){1'b1}}};
        end else if (w_sat_lo) begin
            w_res = {1'b1, {(XLEN - 1){1'b0}}};
        end
    end

    assign w_unused_rnd = ^w_acc_rnd[FRAC-1:0];
`else
    logic w_unused_rnd;

    assign w_res        = w_r[XLEN-1:0];
    assign w_sat        = 1'b0;
    assign w_unused_rnd = ^{w_acc_rnd[FRAC-1:0], w_r[R_W-1:XLEN]};
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_acc        <= '0;
            r_prod       <= '0;
            r_prod_vld   <= 1'b0;
            r_cnt        <= '0;
            r_len_err    <= 1'b0;
            o_out_valid  <= 1'b0;
            o_packet_out <= '0;
            o_sat_flag   <= 1'b0;
            o_len_err    <= 1'b0;
        end else begin
            // Product stage: one registered product per accepted beat.
            r_prod_vld <= w_beat;
            if (w_beat) begin
                r_prod <= w_product;
            end

            // The first beat seeds acc with the bias; its product lands next
            // cycle through the normal add path, like every other beat.
            if (w_beat && (r_state == StIdle)) begin
                r_acc <= w_bias_ext;
            end else if (r_prod_vld) begin
                r_acc <= r_acc + w_prod_ext;
            end

            case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    if (w_beat) begin
                        r_cnt     <= CNT_W'(1);
                        r_len_err <= w_cnt_at_max && !i_in_last;
                        r_state   <= w_end_vec ? StFlush : StAccum;
                    end
                end
                StAccum: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_end_vec) begin
                            r_len_err <= !i_in_last;
                            r_state   <= StFlush;
                        end
                    end
                end
                StFlush: begin
                    // Final product is absorbed by the add path this cycle.
                    r_state <= StRound;
                end
                StRound: begin
                    o_packet_out <= w_res;
                    o_sat_flag   <= w_sat;
                    o_len_err    <= r_len_err;
                    o_out_valid  <= 1'b1;
                    r_state      <= StHold;
                end
                StHold: begin
                    if (i_out_ready) begin
                        o_out_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/lstm_gate_preact.md
# lstm_gate_preact

Computes one LSTM gate pre-activation, z = b + Σ wᵢ·xᵢ, in Q8.8 fixed point by accumulating a serial stream of (weight, operand) beats. It rounds and saturates the wide accumulator back to Q8.8. The result is presented as a `SIGMOID_INPUT_PACKET` to the sigmoid stage directly downstream, one result per input vector, with a valid/ready output handshake.

## Interface
- `XLEN`, default `LSTM_INPUT_BITS` (16): operand, weight, bias and result width, Q8.8 signed.
- `FRAC`, default 8: fractional bits.
- `ACC_W`, default 40: signed accumulator width, holds Q(ACC_W-16).16.
- `MAX_LEN`, default 64: maximum beats per vector.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `in_valid`  in  1  beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_last`  in  1  final beat of the vector.
- `weight`  in  XLEN  signed Q8.8.
- `operand`  in  XLEN  signed Q8.8 (x or h element).
- `bias`  in  XLEN  signed Q8.8; sampled only on the first beat of a vector.
- `out_valid`  out  1  `packet_out` holds a result.
- `out_ready`  in  1  downstream accepts the result.
- `packet_out`  out  `SIGMOID_INPUT_PACKET`  `.data` = Q8.8 pre-activation.
- `sat_flag`  out  1  result was clipped; valid with `out_valid`.
- `len_err`  out  1  vector hit `MAX_LEN` without `in_last`; valid with `out_valid`.

## Operation
- Beat accepted when `in_valid && in_ready`.
- Product stage: signed XLEN×XLEN product registered (Q16.16, 2·XLEN bits), tagged valid.
- Accumulator update each cycle the product register is valid: acc += sign-extended product.
- First beat of a vector: acc loads {bias sign-extended} << FRAC, then the product is added through the normal path.
- FSM:
  - IDLE: `in_ready`=1. A first beat goes to ACCUM, or straight to FLUSH if `in_last`.
  - ACCUM: `in_ready`=1. A beat accepted with `in_last`, or the `MAX_LEN`-th beat, goes to FLUSH.
  - FLUSH: `in_ready`=0. The last product is added to acc. Always goes to ROUND.
  - ROUND: `in_ready`=0. The output is computed and registered. Always goes to HOLD.
  - HOLD: `out_valid`=1, `in_ready`=0. `out_ready` returns to IDLE.
- Output arithmetic: r = (acc + 2^(FRAC-1)) >>> FRAC (round half up). If r > 32767 → 0x7FFF; if r < −32768 → 0x8000; `sat_flag`=1 when clipped.
- Beat counter: clog2(MAX_LEN)+1 bits, cleared in IDLE. Reaching `MAX_LEN` without `in_last` forces FLUSH and sets `len_err` for that result.
- `in_valid` is ignored whenever `in_ready`=0; no beat is lost or double-counted.
- `out_valid && !out_ready`: `packet_out`, `sat_flag` and `len_err` hold stable.
- Reset at any point: FSM→IDLE and acc, product register and counter cleared. A partial vector is discarded with no output produced.

## Timing
- Reset values: `in_ready`=0 during the reset cycle and 1 after. `out_valid`=0, `packet_out.data`=0, `sat_flag`=0, `len_err`=0.
- Throughput: one beat per cycle within a vector.
- Latency: last beat accepted in cycle t → `out_valid`=1 from cycle t+3.
- Minimum vector-to-vector gap: 3 cycles of `in_ready`=0, plus any HOLD stall.
- Handshake completing in cycle h → `in_ready`=1 in cycle h+1 and `out_valid`=0 in cycle h+1.
- The downstream sigmoid adds its own fixed 5-cycle latency after the `out_valid` handshake.

## Configuration
- `LSTM_PREACT_SAT_EN` defined: saturation as above; `sat_flag` is live.
- Not defined: the result is r[XLEN-1:0] (two's-complement wrap) and `sat_flag` is tied to 0.
- Rounding, latency and FSM are identical in both builds.

## Test plan
- Single beat: bias=0x0100, weight=0x0200, operand=0x0180, `in_last`=1 → cycle t+3 `out_valid`=1, data=0x0400, `sat_flag`=0.
- Three beats of weight=0x0100, operand=0x0100, bias=0xFF00, back-to-back → data=0x0200, output exactly 3 cycles after the third beat.
- Four beats of 0x7FFF×0x7FFF, bias=0 → with `LSTM_PREACT_SAT_EN`: data=0x7FFF, `sat_flag`=1. Without it: data=0xFC00, `sat_flag`=0.
- Rounding, bias=0: 0x0001×0x0080 → data=0x0001. 0xFFFF×0x0080 → data=0x0000.
- Backpressure: `out_ready`=0 for 5 cycles with `in_valid`=1 → `packet_out` stable, `in_ready`=0, no beats absorbed. `in_ready`=1 one cycle after the handshake.
- Limits: reset after 2 of 4 beats → `out_valid` stays 0, and the next vector (1×0x0100×0x0100, bias 0) gives 0x0100. Separately, 64 beats without `in_last` → forced result with `len_err`=1.
